sdm_sequencer: RTL



---
 rtl/sdm_sequencer_pkg.sv | 25 ++
 rtl/sdm_sequencer_if.sv | 26 ++
 rtl/sdm_sequencer_interp_phase_gen.sv | 48 ++++
 rtl/sdm_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sdm_sequencer_pkg.sv
// Shared definitions for the sigma-delta DAC run-time controller.
package sdm_ctrl_pkg;

  localparam int STATE_W     = 3;
  localparam int OVL_COUNT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_FLUSH   = 3'd1,
    ST_WARMUP  = 3'd2,
    ST_RUN     = 3'd3,
    ST_RECOVER = 3'd4
  } state_e;

  // States in which the signal source is paced and the phase counter runs.
  function automatic logic is_active(input state_e s);
    logic act;
    case (s)
      ST_WARMUP, ST_RUN, ST_RECOVER: act = 1'b1;
      default:                       act = 1'b0;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/sdm_sequencer_if.sv
// Control/status bundle between the sequencer and the DAC datapath.
interface sdm_sequencer_if;
  import sdm_ctrl_pkg::*;

  logic                   start;
  logic                   stop;
  logic                   ovl_in;
  logic                   sample_req;
  logic                   cic_enable;
  logic                   mod_enable;
  logic                   int_clear;
  logic                   mute;
  logic [STATE_W-1:0]     state;
  logic [OVL_COUNT_W-1:0] ovl_count;

  modport master (
    output start, stop, ovl_in,
    input  sample_req, cic_enable, mod_enable, int_clear, mute, state, ovl_count
  );

  modport slave (
    input  start, stop, ovl_in,
    output sample_req, cic_enable, mod_enable, int_clear, mute, state, ovl_count
  );

endinterface

// File: rtl/sdm_sequencer_interp_phase_gen.sv
// Interpolation phase counter 0..RATE-1 with sync load-zero; exposes the
// next value so consumers can register phase-derived strobes.
module interp_phase_gen #(
  parameter int RATE = 8,
  parameter int PW   = $clog2(RATE) + 1
) (
  input  logic          clck,
  input  logic          rst,
  input  logic          load_zero,
  input  logic          enable,
  output logic [PW-1:0] phase,
  output logic [PW-1:0] phase_next,
  output logic          strobe
);

  logic [PW-1:0] phase_r;
  logic [PW-1:0] phase_s;

  // Next phase: load-zero wins, otherwise wrap at RATE-1 when enabled.
  always_comb begin
    phase_s = phase_r;
    if (load_zero) begin
      phase_s = {PW{1'b0}};
    end else if (enable) begin
      if (phase_r == PW'(RATE - 1)) begin
        phase_s = {PW{1'b0}};
      end else begin
        phase_s = phase_r + PW'(1);
      end
    end else begin
      phase_s = phase_r;
    end
  end

  // Phase register.
  always_ff @(posedge clck) begin
    if (rst) begin
      phase_r <= {PW{1'b0}};
    end else begin
      phase_r <= phase_s;
    end
  end

  assign phase      = phase_r;
  assign phase_next = phase_s;
  assign strobe     = (phase_r == {PW{1'b0}});

endmodule

// File: rtl/sdm_sequencer.sv
// Start-up, pacing and overload-recovery sequencer for the sigma-delta DAC.
// Drives enables/clears only; all outputs are registered Moore decodes.
module sdm_sequencer
  import sdm_ctrl_pkg::*;
#(
  parameter int INTERP_RATE    = 8,
  parameter int FLUSH_CYCLES   = 16,
  parameter int WARMUP_SAMPLES = 4,
  parameter int OVL_LIMIT      = 32,
  parameter int RECOVER_CYCLES = 16
) (
  input  logic           clck,
  input  logic           rst,
  sdm_sequencer_if.slave bus
);

  localparam int PW  = $clog2(INTERP_RATE) + 1;
  localparam int FLW = $clog2(FLUSH_CYCLES) + 1;
  localparam int WMW = $clog2(WARMUP_SAMPLES) + 1;
  localparam int OLW = $clog2(OVL_LIMIT) + 1;
  localparam int RCW = $clog2(RECOVER_CYCLES) + 1;

  state_e                 state_r, state_s;
  logic [FLW-1:0]         flush_cnt_r, flush_cnt_s;
  logic [WMW-1:0]         warm_cnt_r, warm_cnt_s;
  logic [OLW-1:0]         run_cnt_r, run_cnt_s;
  logic [RCW-1:0]         rec_cnt_r, rec_cnt_s;
  logic [OVL_COUNT_W-1:0] ovl_count_r, ovl_count_s;

  logic [PW-1:0] phase_s, phase_next_s;
  logic          phase_zero_s, phase_load_s;

  logic sample_req_r, cic_enable_r, mod_enable_r, int_clear_r, mute_r;
  logic sample_req_s, cic_enable_s, mod_enable_s, int_clear_s, mute_s;

  // Restart phase on WARMUP entry so the first request lands immediately.
  assign phase_load_s = !is_active(state_s) ||
                        ((state_s == ST_WARMUP) && (state_r != ST_WARMUP));

  interp_phase_gen #(
    .RATE (INTERP_RATE),
    .PW   (PW)
  ) u_phase (
    .clck       (clck),
    .rst        (rst),
    .load_zero  (phase_load_s),
    .enable     (1'b1),
    .phase      (phase_s),
    .phase_next (phase_next_s),
    .strobe     (phase_zero_s)
  );

  // Next-state and counter update; stop overrides every other transition.
  always_comb begin
    state_s     = state_r;
    flush_cnt_s = {FLW{1'b0}};
    warm_cnt_s  = {WMW{1'b0}};
    run_cnt_s   = {OLW{1'b0}};
    rec_cnt_s   = {RCW{1'b0}};
    ovl_count_s = ovl_count_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          state_s = ST_FLUSH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_r == FLW'(FLUSH_CYCLES - 1)) begin
          state_s = ST_WARMUP;
        end else begin
          flush_cnt_s = flush_cnt_r + FLW'(1);
        end
      end
      ST_WARMUP: begin
        // Leave on the last phase so RUN begins with a fresh sample.
        if ((warm_cnt_r == WMW'(WARMUP_SAMPLES)) &&
            (phase_s == PW'(INTERP_RATE - 1))) begin
          state_s = ST_RUN;
        end else if (phase_zero_s) begin
          warm_cnt_s = warm_cnt_r + WMW'(1);
        end else begin
          warm_cnt_s = warm_cnt_r;
        end
      end
      ST_RUN: begin
        if (bus.ovl_in) begin
          if (run_cnt_r == OLW'(OVL_LIMIT - 1)) begin
            state_s = ST_RECOVER;
            if (ovl_count_r != {OVL_COUNT_W{1'b1}}) begin
              ovl_count_s = ovl_count_r + OVL_COUNT_W'(1);
            end else begin
              ovl_count_s = ovl_count_r;
            end
          end else begin
            run_cnt_s = run_cnt_r + OLW'(1);
          end
        end else begin
          run_cnt_s = {OLW{1'b0}};
        end
      end
      ST_RECOVER: begin
        if (rec_cnt_r == RCW'(RECOVER_CYCLES - 1)) begin
          state_s = ST_RUN;
        end else begin
          rec_cnt_s = rec_cnt_r + RCW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    if (bus.stop && (state_r != ST_IDLE)) begin
      state_s     = ST_IDLE;
      flush_cnt_s = {FLW{1'b0}};
      warm_cnt_s  = {WMW{1'b0}};
      run_cnt_s   = {OLW{1'b0}};
      rec_cnt_s   = {RCW{1'b0}};
      ovl_count_s = ovl_count_r;
    end else begin
      state_s = state_s;
    end
  end

  // Output decode of the upcoming state, registered below.
  always_comb begin
    cic_enable_s = 1'b0;
    mod_enable_s = 1'b0;
    int_clear_s  = 1'b0;
    mute_s       = 1'b1;
    case (state_s)
      ST_FLUSH: begin
        int_clear_s = 1'b1;
      end
      ST_WARMUP: begin
        cic_enable_s = 1'b1;
      end
      ST_RUN: begin
        cic_enable_s = 1'b1;
        mod_enable_s = 1'b1;
        mute_s       = 1'b0;
      end
      ST_RECOVER: begin
        cic_enable_s = 1'b1;
        int_clear_s  = 1'b1;
      end
      default: begin
        mute_s = 1'b1;
      end
    endcase
    if (is_active(state_s) && (phase_next_s == {PW{1'b0}})) begin
      sample_req_s = 1'b1;
    end else begin
      sample_req_s = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clck) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      flush_cnt_r  <= {FLW{1'b0}};
      warm_cnt_r   <= {WMW{1'b0}};
      run_cnt_r    <= {OLW{1'b0}};
      rec_cnt_r    <= {RCW{1'b0}};
      ovl_count_r  <= {OVL_COUNT_W{1'b0}};
      sample_req_r <= 1'b0;
      cic_enable_r <= 1'b0;
      mod_enable_r <= 1'b0;
      int_clear_r  <= 1'b0;
      mute_r       <= 1'b1;
    end else begin
      state_r      <= state_s;
      flush_cnt_r  <= flush_cnt_s;
      warm_cnt_r   <= warm_cnt_s;
      run_cnt_r    <= run_cnt_s;
      rec_cnt_r    <= rec_cnt_s;
      ovl_count_r  <= ovl_count_s;
      sample_req_r <= sample_req_s;
      cic_enable_r <= cic_enable_s;
      mod_enable_r <= mod_enable_s;
      int_clear_r  <= int_clear_s;
      mute_r       <= mute_s;
    end
  end

  assign bus.state      = state_r;
  assign bus.ovl_count  = ovl_count_r;
  assign bus.sample_req = sample_req_r;
  assign bus.cic_enable = cic_enable_r;
  assign bus.mod_enable = mod_enable_r;
  assign bus.int_clear  = int_clear_r;
  assign bus.mute       = mute_r;

endmodule
